// File: rtl/rsa_host_seq.sv
// rsa_host_seq: host-side sequencer wrapped around the RSA exponentiation core.
// Streams 3*NBYTES operand bytes into the core (modulus, base, exponent, LSB
// first), pulses core_start, waits out core_busy, then streams the NBYTES-byte
// result back out with a valid/ready handshake.
// Optional busy watchdog: define RSA_HOST_SEQ_TIMEOUT_EN to enable it.
module rsa_host_seq #(
  parameter int NBYTES    = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       core_we_n,
  output logic       core_oe_n,
  output logic       core_start,
  output logic [1:0] core_reg_sel,
  output logic [4:0] core_addr,
  output logic [7:0] core_wdata,
  input  logic [7:0] core_rdata,
  input  logic       core_busy,
  output logic       done,
  output logic       err
);

  // LAST_WR covers the cycle in which the final operand write strobe is low.
  typedef enum logic [2:0] {
    ST_LOAD,
    ST_LAST_WR,
    ST_START,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_OUT
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NBYTES - 1);
  localparam logic [1:0] SEL_MOD  = 2'd3;
  localparam logic [1:0] SEL_RES  = 2'd0;

  // Operand field number to core register select: modulus, base, exponent.
  function automatic logic [1:0] fieldSel(input logic [1:0] field);
    case (field)
      2'd1:    return 2'd1;
      2'd2:    return 2'd2;
      default: return SEL_MOD;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [1:0] r_field, w_field_nxt;
  logic [4:0] r_idx, w_idx_nxt;

  logic       r_in_ready, w_in_ready_nxt;
  logic [7:0] r_out_data, w_out_data_nxt;
  logic       r_out_valid, w_out_valid_nxt;
  logic       r_out_last, w_out_last_nxt;
  logic       r_we_n, w_we_n_nxt;
  logic       r_oe_n, w_oe_n_nxt;
  logic       r_start, w_start_nxt;
  logic [1:0] r_reg_sel, w_reg_sel_nxt;
  logic [4:0] r_addr, w_addr_nxt;
  logic [7:0] r_wdata, w_wdata_nxt;
  logic       r_done, w_done_nxt;

`ifdef RSA_HOST_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo, w_tmo_nxt;
  logic                 r_err, w_err_nxt;
`endif

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    w_state_nxt     = r_state;
    w_field_nxt     = r_field;
    w_idx_nxt       = r_idx;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = 1'b0;
    w_out_last_nxt  = r_out_last;
    w_we_n_nxt      = 1'b1;
    w_oe_n_nxt      = 1'b1;
    w_start_nxt     = 1'b0;
    w_reg_sel_nxt   = r_reg_sel;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_done_nxt      = 1'b0;
`ifdef RSA_HOST_SEQ_TIMEOUT_EN
    w_tmo_nxt       = r_tmo;
    w_err_nxt       = r_err;
`endif

    case (r_state)
      ST_LOAD: begin
        if (in_valid && r_in_ready) begin
          w_we_n_nxt    = 1'b0;
          w_reg_sel_nxt = fieldSel(r_field);
          w_addr_nxt    = r_idx;
          w_wdata_nxt   = in_data;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (r_field == 2'd2) begin
              w_field_nxt = '0;
              w_state_nxt = ST_LAST_WR;
            end else begin
              w_field_nxt = r_field + 2'd1;
            end
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end

      ST_LAST_WR: begin
        w_start_nxt = 1'b1;
        w_state_nxt = ST_START;
      end

      ST_START: begin
`ifdef RSA_HOST_SEQ_TIMEOUT_EN
        w_tmo_nxt   = '0;
`endif
        w_state_nxt = ST_WAIT_HI;
      end

      ST_WAIT_HI, ST_WAIT_LO: begin
        if ((r_state == ST_WAIT_HI) && core_busy) begin
          w_state_nxt = ST_WAIT_LO;
`ifdef RSA_HOST_SEQ_TIMEOUT_EN
          if (!(&r_tmo)) w_tmo_nxt = r_tmo + 1'b1;
`endif
        end else if ((r_state == ST_WAIT_LO) && !core_busy) begin
          w_idx_nxt     = '0;
          w_oe_n_nxt    = 1'b0;
          w_reg_sel_nxt = SEL_RES;
          w_addr_nxt    = '0;
          w_state_nxt   = ST_RD_ADDR;
`ifdef RSA_HOST_SEQ_TIMEOUT_EN
        end else if (&r_tmo) begin
          w_err_nxt     = 1'b1;
          w_idx_nxt     = '0;
          w_field_nxt   = '0;
          w_reg_sel_nxt = SEL_MOD;
          w_addr_nxt    = '0;
          w_state_nxt   = ST_LOAD;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
`endif
        end
      end

      ST_RD_ADDR: begin
        w_state_nxt = ST_RD_CAP;
      end

      ST_RD_CAP: begin
        w_out_data_nxt  = core_rdata;
        w_out_valid_nxt = 1'b1;
        w_out_last_nxt  = (r_idx == LAST_IDX);
        w_state_nxt     = ST_OUT;
      end

      ST_OUT: begin
        w_out_valid_nxt = 1'b1;
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          if (r_out_last) begin
            w_done_nxt    = 1'b1;
            w_idx_nxt     = '0;
            w_field_nxt   = '0;
            w_reg_sel_nxt = SEL_MOD;
            w_addr_nxt    = '0;
            w_state_nxt   = ST_LOAD;
          end else begin
            w_idx_nxt     = r_idx + 5'd1;
            w_oe_n_nxt    = 1'b0;
            w_reg_sel_nxt = SEL_RES;
            w_addr_nxt    = r_idx + 5'd1;
            w_state_nxt   = ST_RD_ADDR;
          end
        end
      end

      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == ST_LOAD);
  end

  // State, counters and registered outputs; reset abandons any transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_LOAD;
      r_field     <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_start     <= 1'b0;
      r_reg_sel   <= SEL_MOD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_field     <= w_field_nxt;
      r_idx       <= w_idx_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_we_n      <= w_we_n_nxt;
      r_oe_n      <= w_oe_n_nxt;
      r_start     <= w_start_nxt;
      r_reg_sel   <= w_reg_sel_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_done      <= w_done_nxt;
    end
  end

`ifdef RSA_HOST_SEQ_TIMEOUT_EN
  // Busy watchdog counter and the sticky error flag it raises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= w_tmo_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready     = r_in_ready;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign core_we_n    = r_we_n;
  assign core_oe_n    = r_oe_n;
  assign core_start   = r_start;
  assign core_reg_sel = r_reg_sel;
  assign core_addr    = r_addr;
  assign core_wdata   = r_wdata;
  assign done         = r_done;

endmodule

// File: tb/tb_rsa_host_seq.sv
// tb_rsa_host_seq: self-checking bench for rsa_host_seq with a behavioural
// stand-in for the RSA core (operand memory, busy window, result = addr ^ key).
module tb_rsa_host_seq;

  localparam int NB = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       core_we_n;
  logic       core_oe_n;
  logic       core_start;
  logic [1:0] core_reg_sel;
  logic [4:0] core_addr;
  logic [7:0] core_wdata;
  logic [7:0] core_rdata;
  logic       core_busy;
  logic       done;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] txBytes [3*NB];
  logic [7:0] coreKey;
  logic [7:0] mem [4][NB];
  int         selMap [3] = '{3, 1, 2};
  int         weLow    = 0;
  int         oeLow    = 0;
  int         startCnt = 0;
  int         doneCnt  = 0;
  int         busyTmr;

  rsa_host_seq #(.NBYTES(NB), .TIMEOUT_W(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .core_we_n    (core_we_n),
    .core_oe_n    (core_oe_n),
    .core_start   (core_start),
    .core_reg_sel (core_reg_sel),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_busy    (core_busy),
    .done         (done),
    .err          (err)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Core stand-in: busy window a few cycles after start, registered read data.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busyTmr    <= 0;
      core_busy  <= 1'b0;
      core_rdata <= 8'h00;
    end else begin
      if (core_start)                        busyTmr <= 1;
      else if (busyTmr != 0 && busyTmr < 110) busyTmr <= busyTmr + 1;
      else                                   busyTmr <= 0;
      core_busy <= (busyTmr >= 4 && busyTmr < 104);
      if (!core_oe_n && core_reg_sel == 2'd0) core_rdata <= {3'b000, core_addr} ^ coreKey;
    end
  end

  // Monitor: captures core writes, counts strobe cycles, checks invariants.
  always @(negedge clk) begin
    if (!reset) begin
      if (!core_we_n) begin
        weLow++;
        mem[core_reg_sel][core_addr] = core_wdata;
      end
      if (!core_oe_n) oeLow++;
      if (core_start) startCnt++;
      if (done) doneCnt++;
      check("strobe_overlap", {31'd0, (!core_we_n && !core_oe_n)}, 32'd0);
      check("ready_with_valid", {31'd0, (in_ready && out_valid)}, 32'd0);
    end
  end

  // Hard stop in case the sequence wedges somewhere unbounded.
  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkResetValues(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},   32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid},  32'd0);
    check({tag, "_out_last"},  {31'd0, out_last},   32'd0);
    check({tag, "_out_data"},  {24'd0, out_data},   32'd0);
    check({tag, "_we_n"},      {31'd0, core_we_n},  32'd1);
    check({tag, "_oe_n"},      {31'd0, core_oe_n},  32'd1);
    check({tag, "_start"},     {31'd0, core_start}, 32'd0);
    check({tag, "_reg_sel"},   {30'd0, core_reg_sel}, 32'd3);
    check({tag, "_addr"},      {27'd0, core_addr},  32'd0);
    check({tag, "_wdata"},     {24'd0, core_wdata}, 32'd0);
    check({tag, "_done"},      {31'd0, done},       32'd0);
    check({tag, "_err"},       {31'd0, err},        32'd0);
  endtask

  // Offer nBytes operand bytes, optionally with random gaps in in_valid.
  task automatic applyStimulus(input bit gaps, input int nBytes);
    int k = 0;
    int cyc = 0;
    while (k < nBytes && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = txBytes[k];
      if (in_valid && in_ready) k++;
    end
    check("load_accepted", k, nBytes);
    if (!gaps) check("load_cycles", cyc, nBytes);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Drain the result stream; optionally stall 10 cycles on byte stallIdx.
  task automatic checkOutput(input int stallIdx);
    int i = 0;
    int cyc = 0;
    int oeBefore;
    bit stalled = 0;
    while (i < NB && cyc < 5000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (out_valid && i == stallIdx && !stalled) begin
        stalled   = 1;
        out_ready = 1'b0;
        oeBefore  = oeLow;
        repeat (10) begin
          @(negedge clk);
          #1;
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_data", {24'd0, out_data}, {24'd0, 8'(i) ^ coreKey});
        end
        check("stall_no_extra_oe", oeLow, oeBefore);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        check("out_data", {24'd0, out_data}, {24'd0, 8'(i) ^ coreKey});
        check("out_last", {31'd0, out_last}, {31'd0, (i == NB - 1)});
        i++;
      end
    end
    check("out_count", i, NB);
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("back_in_load", {31'd0, in_ready}, 32'd1);
    check("valid_dropped", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("done_single", {31'd0, done}, 32'd0);
  endtask

  // One complete load / compute / readout transaction with model checks.
  task automatic runTxn(input bit gaps, input int stallIdx);
    int we0, oe0, st0, dn0;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < NB; a++) mem[s][a] = 8'hxx;
    @(negedge clk);
    #1;
    we0 = weLow; oe0 = oeLow; st0 = startCnt; dn0 = doneCnt;
    applyStimulus(gaps, 3 * NB);
    check("tail_in_ready", {31'd0, in_ready}, 32'd0);
    check("tail_we_n", {31'd0, core_we_n}, 32'd0);
    check("tail_reg_sel", {30'd0, core_reg_sel}, 32'd2);
    check("tail_addr", {27'd0, core_addr}, NB - 1);
    check("tail_wdata", {24'd0, core_wdata}, {24'd0, txBytes[3*NB-1]});
    @(negedge clk);
    check("start_high", {31'd0, core_start}, 32'd1);
    check("start_we_n", {31'd0, core_we_n}, 32'd1);
    @(negedge clk);
    check("start_low", {31'd0, core_start}, 32'd0);
    for (int k = 0; k < 3 * NB; k++)
      check($sformatf("mem_byte%0d", k), {24'd0, mem[selMap[k / NB]][k % NB]}, {24'd0, txBytes[k]});
    checkOutput(stallIdx);
    check("we_cycles", weLow - we0, 3 * NB);
    check("oe_cycles", oeLow - oe0, NB);
    check("start_pulses", startCnt - st0, 1);
    check("done_pulses", doneCnt - dn0, 1);
    check("err_clear", {31'd0, err}, 32'd0);
  endtask

  task automatic randomBytes();
    for (int k = 0; k < 3 * NB; k++) txBytes[k] = 8'($urandom);
  endtask

  // Directed and randomized scenario sequence.
  initial begin
    int cyc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    coreKey   = 8'hA5;
    repeat (3) @(negedge clk);
    checkResetValues("por");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("idle");

    $display("[TB] directed load 0x00..0x5F, key A5, stall on byte 7");
    for (int k = 0; k < 3 * NB; k++) txBytes[k] = 8'(k);
    runTxn(1'b0, 7);

    $display("[TB] random load with gaps and random stall");
    randomBytes();
    coreKey = 8'($urandom);
    runTxn(1'b1, int'($urandom_range(0, NB - 1)));

    $display("[TB] reset at the 50th load byte");
    randomBytes();
    applyStimulus(1'b0, 50);
    #2 reset = 1'b1;
    #1 checkResetValues("rst_load");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    randomBytes();
    coreKey = 8'($urandom);
    runTxn(1'b1, int'($urandom_range(0, NB - 1)));

    $display("[TB] reset while waiting for busy to fall");
    randomBytes();
    applyStimulus(1'b1, 3 * NB);
    cyc = 0;
    while (!core_busy && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_seen", {31'd0, core_busy}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 checkResetValues("rst_wait");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    randomBytes();
    coreKey = 8'($urandom);
    runTxn(1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
